sort_scheduler: RTL and testbench
=================================

Name: sort_scheduler

Overview:
Shares the single 17-card hand sorter among N_REQ players (dealer/landlord logic issues one request per player hand). It arbitrates pending requests round-robin and drives the sorter's start pulse and 136-bit hand. It waits for the sorter's output-valid pulse, then captures and returns the sorted hand tagged with the requester ID. It sits between the deal/game FSM and the sorter instance.

Parameters:
N_REQ, 3, number of requesters (players); 2..4 supported
DATA_W, 136, hand width (17 cards x 8 bits)
ID_W, 2, width of requester ID
SORT_TIMEOUT, 1023, max cycles in WAIT before abort (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_i  in  N_REQ  per-player sort request, one-cycle pulse
hand_i  in  N_REQ*DATA_W  flattened hands, player k at [k*DATA_W +: DATA_W]
srt_start  out  1  one-cycle start pulse to sorter
srt_data  out  DATA_W  hand presented to sorter
srt_done  in  1  sorter output-valid pulse (sorted data valid same cycle)
srt_result  in  DATA_W  sorter sorted output
res_valid  out  1  one-cycle pulse, res_data/res_id valid
res_data  out  DATA_W  sorted hand, held until next res_valid
res_id  out  ID_W  requester of res_data
busy  out  1  high in any state other than IDLE
pending_o  out  N_REQ  pending request bits
err_timeout  out  1  one-cycle abort pulse

Behaviour:
- Reset (async, any time, incl. mid-sort): state=IDLE, pending=0, rr pointer=N_REQ-1, srt_start=0, srt_data=0, res_valid=0, res_data=0, res_id=0, err_timeout=0, busy=0, timeout counter=0.
- Pending: req_i[k]=1 sets pending[k]; cleared only at grant of k. Request for k arriving in the grant cycle re-sets pending[k] (set wins) → k served again later. Repeated req while pending: no effect (no counting).
- Arbitration: round-robin, search starts at rr+1 mod N_REQ; winner becomes grant_id; rr <= grant_id at grant.
- FSM: IDLE → START when pending≠0 (grant registered this edge).
- START (1 cycle): srt_start=1, srt_data = hand_i slice of grant_id sampled this cycle; → WAIT.
- WAIT: srt_data held; on srt_done=1 latch res_data<=srt_result, res_id<=grant_id → STORE. srt_done in IDLE/START/STORE ignored.
- STORE (1 cycle): res_valid=1; → IDLE. Minimum back-to-back spacing between two srt_start pulses: 4 cycles + sorter latency.
- Requester must hold its hand_i slice stable from req until its START cycle.
- srt_start, res_valid, err_timeout registered, never high for more than one consecutive cycle.
- ID width: grant_id zero-extended into res_id.

Optional Feature:
SORT_TIMEOUT_EN: defined → counter runs in WAIT; when it reaches SORT_TIMEOUT without srt_done, err_timeout pulses one cycle, no res_valid, res_data unchanged, → IDLE; rr already advanced so next requester served; the aborted request is dropped (not re-pended). srt_done on the exact timeout cycle wins (normal STORE, no error). Undefined → no counter, WAIT persists until srt_done, err_timeout tied 0.

Test Plan:
- Single req: req_i=3'b001, hand0 = 17 unsorted bytes; sorter model done after 300 cycles → srt_start one pulse with srt_data=hand0, then res_valid with res_id=0, res_data=sorter output, busy low next cycle.
- Simultaneous req_i=3'b111 from reset → served order 0,1,2, three res_valid pulses, res_id 0,1,2, pending_o 111→110→100→000.
- Fairness: player 0 re-requests each time it is served while 1,2 pending → order 0,1,2,0, never 0,0.
- Re-request during own grant cycle → pending[k] stays 1, k served twice, two res_valid with same res_id.
- Reset asserted in WAIT → all outputs zero immediately (async), later spurious srt_done ignored, no res_valid.
- With SORT_TIMEOUT_EN, SORT_TIMEOUT=20, sorter never answers → err_timeout pulse 20 cycles after WAIT entry, no res_valid, next pending player started; without macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/sort_scheduler.sv
// sort_scheduler: shares one 17-card hand sorter among N_REQ players.
// Pending requests are arbitrated round-robin. The winner's hand is sent to the
// sorter with a one-cycle start pulse. The sorted result is returned tagged with
// the requester ID.
// Optional feature macro: SORT_TIMEOUT_EN. When it is defined, a request in WAIT
// is aborted after SORT_TIMEOUT cycles without srt_done.
module sort_scheduler #(
    parameter int N_REQ        = 3,
    parameter int DATA_W       = 136,
    parameter int ID_W         = 2,
    parameter int SORT_TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] hand_i,
    output logic                    srt_start,
    output logic [DATA_W-1:0]       srt_data,
    input  logic                    srt_done,
    input  logic [DATA_W-1:0]       srt_result,
    output logic                    res_valid,
    output logic [DATA_W-1:0]       res_data,
    output logic [ID_W-1:0]         res_id,
    output logic                    busy,
    output logic [N_REQ-1:0]        pending_o,
    output logic                    err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic                srt_start_q, srt_start_d;
    logic [DATA_W-1:0]   srt_data_q, srt_data_d;
    logic                res_valid_q, res_valid_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [ID_W-1:0]     res_id_q, res_id_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [ID_W-1:0]     win_s;
    logic [ID_W-1:0]     idx_s;
    logic                found_s;
    logic [N_REQ-1:0]    win_mask_s;
    logic [DATA_W-1:0]   sel_hand_s;

`ifdef SORT_TIMEOUT_EN
    localparam int CNT_W = $clog2(SORT_TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        win_s   = rr_q;
        idx_s   = rr_q;
        found_s = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx_s = ID_W'((32'(rr_q) + i) % N_REQ);
            if (!found_s && pending_q[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        win_mask_s = N_REQ'(1'b1) << win_s;
    end

    // Hand slice of the arbitration winner, selected with constant indices.
    always_comb begin
        sel_hand_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_s == ID_W'(k)) begin
                sel_hand_s = hand_i[k*DATA_W +: DATA_W];
            end else begin
                sel_hand_s = sel_hand_s;
            end
        end
    end

    // Next-state and registered-output logic of the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | req_i;
        rr_d        = rr_q;
        grant_d     = grant_q;
        srt_start_d = 1'b0;
        srt_data_d  = srt_data_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        err_d       = 1'b0;
`ifdef SORT_TIMEOUT_EN
        cnt_d       = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    // A request arriving in the grant cycle sets the bit again.
                    pending_d   = (pending_q & ~win_mask_s) | req_i;
                    grant_d     = win_s;
                    rr_d        = win_s;
                    srt_start_d = 1'b1;
                    srt_data_d  = sel_hand_s;
                    state_d     = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (srt_done) begin
                    res_data_d  = srt_result;
                    res_id_d    = grant_q;
                    res_valid_d = 1'b1;
                    state_d     = S_STORE;
                end else begin
`ifdef SORT_TIMEOUT_EN
                    if (cnt_q == CNT_W'(SORT_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_WAIT;
                    end
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_STORE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            rr_q        <= ID_W'(N_REQ - 1);
            grant_q     <= '0;
            srt_start_q <= 1'b0;
            srt_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef SORT_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            srt_start_q <= srt_start_d;
            srt_data_q  <= srt_data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
`ifdef SORT_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign srt_start   = srt_start_q;
    assign srt_data    = srt_data_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_id      = res_id_q;
    assign busy        = busy_q;
    assign pending_o   = pending_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_sort_scheduler.sv
// Self-checking bench for sort_scheduler (default build, N_REQ=3).
module tb_sort_scheduler;

    localparam int N  = 3;
    localparam int DW = 136;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_i = '0;
    logic [N*DW-1:0] hand_bus;
    logic            srt_start;
    logic [DW-1:0]   srt_data;
    logic            srt_done;
    logic [DW-1:0]   srt_result;
    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic [IW-1:0]   res_id;
    logic            busy;
    logic [N-1:0]    pending_o;
    logic            err_timeout;

    logic [DW-1:0]   hands [N];
    int              checks = 0;
    int              errors = 0;

    // sorter stub controls
    int              lat_v = 5;
    logic            sorter_en = 1'b1;
    logic            force_done = 1'b0;
    logic            model_done;
    logic            busy_m;
    int              cnt_m;
    logic [DW-1:0]   cap_m;
    logic [DW-1:0]   model_res;

    always #5 clk = ~clk;

    sort_scheduler #(.N_REQ(N), .DATA_W(DW), .ID_W(IW), .SORT_TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .hand_i(hand_bus),
        .srt_start(srt_start), .srt_data(srt_data), .srt_done(srt_done),
        .srt_result(srt_result), .res_valid(res_valid), .res_data(res_data),
        .res_id(res_id), .busy(busy), .pending_o(pending_o), .err_timeout(err_timeout)
    );

    function automatic logic [DW-1:0] sort_hand(input logic [DW-1:0] h);
        logic [7:0] b [17];
        logic [7:0] t;
        logic [DW-1:0] r;
        for (int i = 0; i < 17; i++) b[i] = h[i*8 +: 8];
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16 - i; j++)
                if (b[j] > b[j+1]) begin t = b[j]; b[j] = b[j+1]; b[j+1] = t; end
        for (int i = 0; i < 17; i++) r[i*8 +: 8] = b[i];
        return r;
    endfunction

    // Sorter stub: captures the hand on start, answers lat_v+1 cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_m     <= 1'b0;
            cnt_m      <= 0;
            model_done <= 1'b0;
            cap_m      <= '0;
            model_res  <= '0;
        end else begin
            model_done <= 1'b0;
            if (busy_m) begin
                if (cnt_m <= 1) begin
                    model_done <= 1'b1;
                    model_res  <= sort_hand(cap_m);
                    busy_m     <= 1'b0;
                end else begin
                    cnt_m <= cnt_m - 1;
                end
            end else if (srt_start && sorter_en) begin
                cap_m  <= srt_data;
                cnt_m  <= lat_v;
                busy_m <= 1'b1;
            end
        end
    end

    assign srt_done   = model_done | force_done;
    assign srt_result = model_res;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_req(input logic [N-1:0] m);
        req_i = m;
        @(negedge clk);
        req_i = '0;
    endtask

    // Wait for one service of player id and check the whole handshake.
    task automatic serve(input int id, input logic [N-1:0] exp_pend, input logic [N-1:0] rereq);
        int t;
        t = 0;
        while (!srt_start && t < 2000) begin @(negedge clk); t++; end
        chk("start_seen", DW'(srt_start), DW'(1'b1));
        chk("srt_data", srt_data, hands[id]);
        chk("pending", DW'(pending_o), DW'(exp_pend));
        @(negedge clk);
        chk("start_pulse_width", DW'(srt_start), DW'(1'b0));
        t = 0;
        while (!res_valid && t < 2000) begin @(negedge clk); t++; end
        chk("res_valid_seen", DW'(res_valid), DW'(1'b1));
        chk("res_id", DW'(res_id), DW'(id));
        chk("res_data", res_data, sort_hand(hands[id]));
        req_i = rereq;
        @(negedge clk);
        req_i = '0;
        chk("res_valid_width", DW'(res_valid), DW'(1'b0));
        chk("busy_after", DW'(busy), DW'(1'b0));
    endtask

    typedef struct packed {
        logic        do_rst;
        logic [2:0]  req;
        logic [15:0] lat;
        logic [1:0]  nserv;
        logic [5:0]  ids;   // {third, second, first}
        logic [8:0]  pend;  // {third, second, first} pending at START
    } vec_t;

    vec_t vecs [5];

    initial begin
        int t;
        logic bad;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 17; j++)
                hands[k][j*8 +: 8] = 8'((j * 37 + k * 71 + 13) % 256);
            hand_bus[k*DW +: DW] = hands[k];
        end

        vecs[0] = '{1'b1, 3'b001, 16'd300, 2'd1, {2'd0, 2'd0, 2'd0}, {3'b000, 3'b000, 3'b000}};
        vecs[1] = '{1'b1, 3'b111, 16'd5,   2'd3, {2'd2, 2'd1, 2'd0}, {3'b000, 3'b100, 3'b110}};
        vecs[2] = '{1'b0, 3'b110, 16'd3,   2'd2, {2'd0, 2'd2, 2'd1}, {3'b000, 3'b000, 3'b100}};
        vecs[3] = '{1'b0, 3'b101, 16'd1,   2'd2, {2'd0, 2'd2, 2'd0}, {3'b000, 3'b000, 3'b100}};
        vecs[4] = '{1'b0, 3'b011, 16'd2,   2'd2, {2'd0, 2'd1, 2'd0}, {3'b000, 3'b000, 3'b010}};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", DW'({srt_start, res_valid, busy, pending_o, err_timeout, res_id}), DW'(0));
        chk("reset_srt_data", srt_data, DW'(0));
        chk("reset_res_data", res_data, DW'(0));
        rst = 1'b0;
        @(negedge clk);

        // table-driven services
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_rst) do_reset();
            lat_v = int'(vecs[v].lat);
            pulse_req(vecs[v].req);
            for (int s = 0; s < int'(vecs[v].nserv); s++)
                serve(int'(vecs[v].ids[s*2 +: 2]), vecs[v].pend[s*3 +: 3], 3'b000);
        end

        // fairness: player 0 re-requests when served, order 0,1,2,0
        do_reset();
        lat_v = 4;
        pulse_req(3'b111);
        serve(0, 3'b110, 3'b001);
        serve(1, 3'b101, 3'b000);
        serve(2, 3'b001, 3'b000);
        serve(0, 3'b000, 3'b000);

        // re-request in own grant cycle: served twice
        req_i = 3'b010;
        repeat (2) @(negedge clk);
        req_i = '0;
        serve(1, 3'b010, 3'b000);
        serve(1, 3'b000, 3'b000);

        // reset in WAIT, then spurious srt_done ignored
        lat_v = 50;
        pulse_req(3'b100);
        t = 0;
        while (!srt_start && t < 100) begin @(negedge clk); t++; end
        chk("wait_start_seen", DW'(srt_start), DW'(1'b1));
        repeat (5) @(negedge clk);
        chk("busy_in_wait", DW'(busy), DW'(1'b1));
        rst = 1'b1;
        #1;
        chk("async_rst_ctrl", DW'({srt_start, res_valid, busy, pending_o, err_timeout, res_id}), DW'(0));
        chk("async_rst_data", srt_data | res_data, DW'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (res_valid || busy) bad = 1'b1;
            @(negedge clk);
        end
        chk("spurious_done_ignored", DW'(bad), DW'(1'b0));

        // sorter never answers
        sorter_en = 1'b0;
        pulse_req(3'b001);
        t = 0;
        while (!srt_start && t < 100) begin @(negedge clk); t++; end
        chk("hang_start_seen", DW'(srt_start), DW'(1'b1));
`ifdef SORT_TIMEOUT_EN
        t = 0;
        while (!err_timeout && t < 100) begin @(negedge clk); t++; end
        chk("timeout_pulse", DW'(err_timeout), DW'(1'b1));
        chk("timeout_no_res", DW'(res_valid), DW'(1'b0));
`else
        bad = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            if (!busy || err_timeout || res_valid) bad = 1'b1;
            @(negedge clk);
        end
        chk("wait_persists", DW'(bad), DW'(1'b0));
`endif
        sorter_en = 1'b1;
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
